// File: rtl/decision_scan.sv
// Static-order decision scanner: finds the lowest-index free variable
// slice by slice, returns it one-hot with its saved phase, tracks level.
module decision_scan #(
    parameter int NUM_VARS  = 32,
    parameter int SLICE     = 8,
    parameter int WIDTH_LVL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_lvl_en,
    input  logic [WIDTH_LVL-1:0]  load_lvl_i,
    input  logic                  decision_pulse,
    input  logic [NUM_VARS*3-1:0] vars_value_i,
    output logic [NUM_VARS-1:0]   index_decided_o,
    output logic [1:0]            value_decided_o,
    output logic                  decision_done,
    output logic                  all_assigned_o,
    output logic                  busy_o,
    input  logic                  apply_bkt_i,
    input  logic [WIDTH_LVL-1:0]  bkt_lvl_i,
    output logic [WIDTH_LVL-1:0]  cur_lvl_o
);

    localparam int NUM_SLICES = NUM_VARS / SLICE;
    localparam int PTR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLICES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [NUM_VARS-1:0] IDX_ONE = {{(NUM_VARS-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_LVL-1:0] LVL_ONE = {{(WIDTH_LVL-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE,
        S_FAIL
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_VARS-1:0]  phase_q, phase_d;
    logic [WIDTH_LVL-1:0] next_lvl_q, next_lvl_d;
    logic [NUM_VARS-1:0]  index_q, index_d;
    logic [1:0]           value_q, value_d;

    logic [NUM_VARS-1:0]  free_vec;
    logic [NUM_VARS-1:0]  unused_implied;
    logic [SLICE-1:0]     slice_free;
    logic [SLICE-1:0]     slice_phase;
    logic [31:0]          base;
    logic                 hit;
    logic                 hit_phase;
    logic [NUM_VARS-1:0]  hit_oh;

    // Free map, and phase capture from every currently assigned variable
    always_comb begin
        free_vec       = '0;
        unused_implied = '0;
        phase_d        = phase_q;
        for (int i = 0; i < NUM_VARS; i++) begin
            free_vec[i]       = (vars_value_i[3*i+1 +: 2] == 2'b00);
            unused_implied[i] = vars_value_i[3*i];
            if (vars_value_i[3*i+1 +: 2] == 2'b01) begin
                phase_d[i] = 1'b0;
            end else if (vars_value_i[3*i+1 +: 2] == 2'b10) begin
                phase_d[i] = 1'b1;
            end
        end
    end

    // Lowest free variable inside the slice under the pointer
    always_comb begin
        base        = 32'(ptr_q) * 32'(SLICE);
        slice_free  = SLICE'(free_vec >> base);
        slice_phase = SLICE'(phase_q >> base);
        hit         = 1'b0;
        hit_phase   = 1'b0;
        hit_oh      = '0;
        for (int j = SLICE - 1; j >= 0; j--) begin
            if (slice_free[j]) begin
                hit       = 1'b1;
                hit_phase = slice_phase[j];
                hit_oh    = IDX_ONE << (base + 32'(j));
            end
        end
    end

    // Scan FSM next state, decision capture and level update
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        index_d    = '0;
        value_d    = 2'b00;
        next_lvl_d = next_lvl_q;
        unique case (state_q)
            S_IDLE: begin
                if (decision_pulse) begin
                    state_d = S_SCAN;
                    ptr_d   = '0;
                end
            end
            S_SCAN: begin
                if (apply_bkt_i) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    state_d = S_DONE;
                    index_d = hit_oh;
                    value_d = hit_phase ? 2'b10 : 2'b01;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = S_FAIL;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (load_lvl_en) begin
            next_lvl_d = load_lvl_i;
        end else if (state_q == S_DONE) begin
            next_lvl_d = next_lvl_q + LVL_ONE;
        end else if (apply_bkt_i) begin
            next_lvl_d = bkt_lvl_i;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            phase_q    <= '0;
            next_lvl_q <= '1;
            index_q    <= '0;
            value_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            next_lvl_q <= next_lvl_d;
            index_q    <= index_d;
            value_q    <= value_d;
        end
    end

    assign index_decided_o = index_q;
    assign value_decided_o = value_q;
    assign decision_done   = (state_q == S_DONE);
    assign all_assigned_o  = (state_q == S_FAIL);
    assign busy_o          = (state_q == S_SCAN);
    assign cur_lvl_o       = next_lvl_q - LVL_ONE;

endmodule

// File: tb/tb_decision_scan.sv
// Bench for decision_scan: directed scenarios plus randomized variable
// maps checked against a first-free-variable reference model.
module tb_decision_scan;

    localparam int NV = 32;
    localparam int SL = 8;
    localparam int WL = 16;
    localparam int NS = NV / SL;

    logic            clk;
    logic            rst;
    logic            load_lvl_en;
    logic [WL-1:0]   load_lvl_i;
    logic            decision_pulse;
    logic [NV*3-1:0] vars_value_i;
    logic [NV-1:0]   index_decided_o;
    logic [1:0]      value_decided_o;
    logic            decision_done;
    logic            all_assigned_o;
    logic            busy_o;
    logic            apply_bkt_i;
    logic [WL-1:0]   bkt_lvl_i;
    logic [WL-1:0]   cur_lvl_o;

    int checks = 0;
    int errors = 0;

    logic [NV-1:0] mphase;
    logic [WL-1:0] mlvl;

    decision_scan #(
        .NUM_VARS  (NV),
        .SLICE     (SL),
        .WIDTH_LVL (WL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_lvl_en     (load_lvl_en),
        .load_lvl_i      (load_lvl_i),
        .decision_pulse  (decision_pulse),
        .vars_value_i    (vars_value_i),
        .index_decided_o (index_decided_o),
        .value_decided_o (value_decided_o),
        .decision_done   (decision_done),
        .all_assigned_o  (all_assigned_o),
        .busy_o          (busy_o),
        .apply_bkt_i     (apply_bkt_i),
        .bkt_lvl_i       (bkt_lvl_i),
        .cur_lvl_o       (cur_lvl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phase memory: last polarity each variable was assigned
    always @(posedge clk) begin
        if (!rst) begin
            mphase <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (vars_value_i[3*i+2 -: 2] == 2'b01) mphase[i] <= 1'b0;
                if (vars_value_i[3*i+2 -: 2] == 2'b10) mphase[i] <= 1'b1;
            end
        end
    end

    task automatic set_var(input int i, input logic [1:0] v);
        vars_value_i[3*i +: 3] = {v, 1'($urandom_range(0, 1))};
    endtask

    function automatic logic [1:0] rand_asg();
        return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    endfunction

    // Variables below f assigned, f free, above f anything
    task automatic make_first_free(input int f);
        for (int i = 0; i < NV; i++) begin
            if (i < f) set_var(i, rand_asg());
            else if (i == f) set_var(i, 2'b00);
            else set_var(i, 2'($urandom_range(0, 2)));
        end
    endtask

    function automatic logic [NV-1:0] onehot(input int f);
        logic [NV-1:0] r;
        r = '0;
        r[f] = 1'b1;
        return r;
    endfunction

    // Pulse now (caller sits on a negedge), wait for done/fail, bounded
    task automatic pulse_and_wait(output int lat, output logic dn,
                                  output logic fl,
                                  output logic [NV-1:0] idx,
                                  output logic [1:0] val);
        decision_pulse = 1'b1;
        @(negedge clk);
        lat = 1;
        decision_pulse = 1'b0;
        while (lat < 20 && !decision_done && !all_assigned_o) begin
            @(negedge clk);
            lat++;
        end
        dn  = decision_done;
        fl  = all_assigned_o;
        idx = index_decided_o;
        val = value_decided_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({decision_done, all_assigned_o, busy_o,
             index_decided_o, value_decided_o} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h/%h d%b f%b b%b required all 0",
                     index_decided_o, value_decided_o,
                     decision_done, all_assigned_o, busy_o);
        end
        checks++;
        if (cur_lvl_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL reset_lvl: got %h required fffe", cur_lvl_o);
        end
        rst = 1'b1;
        mlvl = '1;
    endtask

    task automatic test_all_free();
        int lat;
        logic dn, fl;
        logic [NV-1:0] idx;
        logic [1:0] val;
        @(negedge clk);
        for (int i = 0; i < NV; i++) set_var(i, 2'b00);
        pulse_and_wait(lat, dn, fl, idx, val);
        checks++;
        if (lat !== 2 || {dn, fl} !== 2'b10 || idx !== 32'h1 || val !== 2'b01) begin
            errors++;
            $display("FAIL all_free_1: got lat%0d d%b f%b %h %b required 2 1 0 00000001 01",
                     lat, dn, fl, idx, val);
        end
        @(negedge clk);
        mlvl++;
        checks++;
        if (cur_lvl_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL all_free_lvl1: got %h required ffff", cur_lvl_o);
        end
        set_var(0, 2'b10);
        pulse_and_wait(lat, dn, fl, idx, val);
        checks++;
        if (lat !== 2 || {dn, fl} !== 2'b10 || idx !== 32'h2 || val !== 2'b01) begin
            errors++;
            $display("FAIL all_free_2: got lat%0d d%b f%b %h %b required 2 1 0 00000002 01",
                     lat, dn, fl, idx, val);
        end
        @(negedge clk);
        mlvl++;
        checks++;
        if (cur_lvl_o !== 16'h0000) begin
            errors++;
            $display("FAIL all_free_lvl2: got %h required 0000", cur_lvl_o);
        end
    endtask

    task automatic test_last_slice();
        int lat;
        logic dn, fl;
        logic [NV-1:0] idx;
        logic [1:0] val;
        @(negedge clk);
        make_first_free(27);
        pulse_and_wait(lat, dn, fl, idx, val);
        checks++;
        if (lat !== 5 || {dn, fl} !== 2'b10 || idx !== 32'h0800_0000 ||
            val !== (mphase[27] ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL var27: got lat%0d d%b f%b %h %b required 5 1 0 08000000",
                     lat, dn, fl, idx, val);
        end
        @(negedge clk);
        mlvl++;
        make_first_free(NV);
        pulse_and_wait(lat, dn, fl, idx, val);
        checks++;
        if (lat !== NS + 1 || {dn, fl} !== 2'b01 || idx !== '0) begin
            errors++;
            $display("FAIL all_assigned: got lat%0d d%b f%b %h required %0d 0 1 0",
                     lat, dn, fl, idx, NS + 1);
        end
        @(negedge clk);
        checks++;
        if (cur_lvl_o !== mlvl - 16'd1) begin
            errors++;
            $display("FAIL fail_lvl: got %h required %h", cur_lvl_o, mlvl - 16'd1);
        end
    endtask

    task automatic test_phase();
        int lat;
        logic dn, fl;
        logic [NV-1:0] idx;
        logic [1:0] val;
        @(negedge clk);
        make_first_free(6);
        set_var(5, 2'b10);
        @(negedge clk);
        set_var(5, 2'b00);
        pulse_and_wait(lat, dn, fl, idx, val);
        checks++;
        if (lat !== 2 || {dn, fl} !== 2'b10 || idx !== 32'h20 || val !== 2'b10) begin
            errors++;
            $display("FAIL phase: got lat%0d d%b f%b %h %b required 2 1 0 00000020 10",
                     lat, dn, fl, idx, val);
        end
        @(negedge clk);
        mlvl++;
    endtask

    task automatic test_bkt_abort();
        int cnt;
        @(negedge clk);
        make_first_free(30);
        decision_pulse = 1'b1;
        @(negedge clk);
        decision_pulse = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL bkt_busy: got %b required 1", busy_o);
        end
        @(negedge clk);
        apply_bkt_i = 1'b1;
        bkt_lvl_i = 16'd3;
        @(negedge clk);
        apply_bkt_i = 1'b0;
        mlvl = 16'd3;
        checks++;
        if (busy_o !== 1'b0 || cur_lvl_o !== 16'd2) begin
            errors++;
            $display("FAIL bkt_abort: got busy%b lvl%h required 0 0002",
                     busy_o, cur_lvl_o);
        end
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (decision_done || all_assigned_o) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL bkt_no_pulse: got %0d pulses required 0", cnt);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        logic dn, fl;
        logic [NV-1:0] idx;
        logic [1:0] val;
        @(negedge clk);
        make_first_free($urandom_range(0, SL - 1));
        pulse_and_wait(lat, dn, fl, idx, val);
        load_lvl_en = 1'b1;
        load_lvl_i = 16'd10;
        @(negedge clk);
        load_lvl_en = 1'b0;
        mlvl = 16'd10;
        checks++;
        if (dn !== 1'b1 || cur_lvl_o !== 16'd9) begin
            errors++;
            $display("FAIL load_in_done: got d%b lvl%h required 1 0009", dn, cur_lvl_o);
        end
        make_first_free($urandom_range(0, NV - 1));
        pulse_and_wait(lat, dn, fl, idx, val);
        apply_bkt_i = 1'b1;
        bkt_lvl_i = 16'h1234;
        @(negedge clk);
        apply_bkt_i = 1'b0;
        mlvl++;
        checks++;
        if (dn !== 1'b1 || cur_lvl_o !== 16'd10) begin
            errors++;
            $display("FAIL bkt_in_done: got d%b lvl%h required 1 000a", dn, cur_lvl_o);
        end
        make_first_free(20);
        decision_pulse = 1'b1;
        @(negedge clk);
        decision_pulse = 1'b0;
        load_lvl_en = 1'b1;
        load_lvl_i = 16'd50;
        lat = 1;
        @(negedge clk);
        load_lvl_en = 1'b0;
        lat++;
        while (lat < 20 && !decision_done && !all_assigned_o) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (decision_done !== 1'b1 || lat !== 4 || index_decided_o !== onehot(20)) begin
            errors++;
            $display("FAIL load_in_scan: got d%b lat%0d %h required 1 4 %h",
                     decision_done, lat, index_decided_o, onehot(20));
        end
        @(negedge clk);
        mlvl = 16'd51;
        checks++;
        if (cur_lvl_o !== 16'd50) begin
            errors++;
            $display("FAIL load_in_scan_lvl: got %h required 0032", cur_lvl_o);
        end
    endtask

    task automatic test_back_to_back();
        int cnt, dlat, f;
        logic [NV-1:0] didx;
        @(negedge clk);
        f = 16 + $urandom_range(0, SL - 1);
        make_first_free(f);
        decision_pulse = 1'b1;
        cnt = 0;
        dlat = -1;
        didx = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (decision_done) begin
                cnt++;
                dlat = c;
                didx = index_decided_o;
            end
            if (c == 5) decision_pulse = 1'b0;
        end
        mlvl++;
        checks++;
        if (cnt !== 1 || dlat !== 4 || didx !== onehot(f)) begin
            errors++;
            $display("FAIL back_to_back: got %0d dones lat%0d %h required 1 4 %h",
                     cnt, dlat, didx, onehot(f));
        end
        checks++;
        if (cur_lvl_o !== mlvl - 16'd1) begin
            errors++;
            $display("FAIL back_to_back_lvl: got %h required %h",
                     cur_lvl_o, mlvl - 16'd1);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cnt;
        @(negedge clk);
        make_first_free(25);
        decision_pulse = 1'b1;
        @(negedge clk);
        decision_pulse = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({decision_done, all_assigned_o, busy_o,
             index_decided_o, value_decided_o} !== '0 ||
            cur_lvl_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL reset_mid: got %h/%h d%b f%b b%b lvl%h required 0 fffe",
                     index_decided_o, value_decided_o, decision_done,
                     all_assigned_o, busy_o, cur_lvl_o);
        end
        rst = 1'b1;
        mlvl = '1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (decision_done || all_assigned_o || busy_o) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles required 0", cnt);
        end
    endtask

    task automatic test_random();
        int lat, f, elat;
        logic dn, fl;
        logic [NV-1:0] idx;
        logic [1:0] val;
        logic [1:0] eval;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            f = $urandom_range(0, NV);
            make_first_free(f);
            pulse_and_wait(lat, dn, fl, idx, val);
            if (f < NV) begin
                elat = f / SL + 2;
                eval = mphase[f] ? 2'b10 : 2'b01;
                checks++;
                if (lat !== elat || {dn, fl} !== 2'b10 ||
                    idx !== onehot(f) || val !== eval) begin
                    errors++;
                    $display("FAIL rand_done[%0d]: got lat%0d d%b f%b %h %b required %0d 1 0 %h %b",
                             it, lat, dn, fl, idx, val, elat, onehot(f), eval);
                end
                mlvl++;
            end else begin
                checks++;
                if (lat !== NS + 1 || {dn, fl} !== 2'b01 || idx !== '0) begin
                    errors++;
                    $display("FAIL rand_fail[%0d]: got lat%0d d%b f%b %h required %0d 0 1 0",
                             it, lat, dn, fl, idx, NS + 1);
                end
            end
            @(negedge clk);
            checks++;
            if (cur_lvl_o !== mlvl - 16'd1) begin
                errors++;
                $display("FAIL rand_lvl[%0d]: got %h required %h",
                         it, cur_lvl_o, mlvl - 16'd1);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        load_lvl_en = 1'b0;
        load_lvl_i = '0;
        decision_pulse = 1'b0;
        vars_value_i = '0;
        apply_bkt_i = 1'b0;
        bkt_lvl_i = '0;
        mlvl = '1;
        test_reset();
        test_all_free();
        test_last_slice();
        test_phase();
        test_bkt_abort();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
